vec_op_sequencer: RTL and testbench
===================================

// Module: vec_op_sequencer
// PURPOSE
//  Sequences one vec_alu instance over whole vectors held in a vector register file (VRF).
//  Accepts one command per operation: opcode, two source base addresses, destination base,
//  length and modulus q. Streams one element per cycle: VRF read -> ALU -> VRF write.
//  Sits between the NTT/VM command decoder and the VRF + vec_alu pair.
// PARAMETERS
//  DATA_W  64  element / modulus width; must match the vec_alu datapath (64)
//  ADDR_W  10  VRF address width; cmd_len is ADDR_W+1 bits (max 2^ADDR_W elements)
// PORTS
//  clk          in   1         clock; all logic on the rising edge
//  rst_n        in   1         asynchronous reset, active-low
//  cmd_valid    in   1         command present
//  cmd_ready    out  1         high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_op       in   3         0=ADD 1=SUB 2=MULT; 3..7 illegal
//  cmd_src_a    in   ADDR_W    operand A base address
//  cmd_src_b    in   ADDR_W    operand B base address
//  cmd_dst      in   ADDR_W    result base address
//  cmd_len      in   ADDR_W+1  element count, 0..2^ADDR_W
//  cmd_q        in   DATA_W    modulus for this command
//  busy         out  1         state != IDLE
//  done         out  1         1-cycle pulse at end of every accepted command
//  err          out  1         valid with done: 1 = illegal opcode, no writes issued
//  rd_en        out  1         VRF read strobe; read data returns 1 cycle later
//  rd_addr_a    out  ADDR_W    VRF port A read address
//  rd_addr_b    out  ADDR_W    VRF port B read address
//  rd_data_a    in   DATA_W    VRF port A data (cycle after rd_en)
//  rd_data_b    in   DATA_W    VRF port B data (cycle after rd_en)
//  alu_opcode   out  3         latched cmd_op; drives vec_alu opcode
//  alu_a        out  DATA_W    combinational pass-through of rd_data_a
//  alu_b        out  DATA_W    combinational pass-through of rd_data_b
//  alu_q        out  DATA_W    latched cmd_q
//  alu_res      in   DATA_W    vec_alu res_out (combinational)
//  wr_en        out  1         VRF write strobe
//  wr_addr      out  ADDR_W    VRF write address
//  wr_data      out  DATA_W    registered alu_res
// BEHAVIOUR
//  - Reset (async, any state, including mid-command): state=IDLE; cmd_ready=1.
//    busy, done, err, rd_en and wr_en are 0. All address/data/opcode/q registers are 0.
//    In-flight reads and writes are dropped.
//  - FSM: IDLE -> RUN on an accept with cmd_len>0 and a legal opcode.
//    IDLE -> DONE on an accept with cmd_len==0 (err=0) or an illegal opcode (err=1).
//    RUN -> DRAIN after the read of element len-1 is issued.
//    DRAIN -> DONE after the last wr_en cycle. DONE -> IDLE unconditionally.
//  - On accept, latch op, q, bases and len. alu_opcode and alu_q hold constant until the next accept.
//  - Pipeline; E0 = accept edge, element i = 0..len-1:
//      cycle 1+i: rd_en=1, rd_addr_a=src_a+i, rd_addr_b=src_b+i
//      cycle 2+i: rd_data valid -> alu_a/alu_b; alu_res registered into wr_data
//      cycle 3+i: wr_en=1, wr_addr=dst+i, wr_data=result
//    Throughput is one element per cycle with no bubbles.
//    done=1 in cycle len+3; cmd_ready=1 again from cycle len+4.
//    For len==0 or an illegal opcode: done (and err if applicable) in cycle 1; no rd_en or wr_en.
//  - Address arithmetic is modulo 2^ADDR_W: base+i wraps, e.g. base 1023, len 2 -> 1023, 0.
//  - Results are defined when dst==src_a or dst==src_b (writes lag reads by 2 cycles),
//    or when the dst range is disjoint from both source ranges. Other overlaps are undefined.
//  - cmd_* inputs are ignored while cmd_ready=0. Back-to-back commands are separated by
//    the DONE cycle plus the IDLE accept cycle.
// CONFIGURATION
//  Macro VEC_SEQ_PERF_EN.
//  - Defined: adds outputs perf_cmds[31:0] (+1 per done pulse) and perf_busy[31:0]
//    (+1 per cycle with busy=1). Both are reset to 0, wrap at 2^32, and are read-only.
//  - Undefined: neither port nor its counter exists; all other behaviour is identical.
// TESTING
//  1. ADD, q=97, src_a=0 {10,90}, src_b=16 {5,20}, dst=32, len=2 ->
//     wr@cycle3 (32,15), wr@cycle4 (33,13); done@cycle5.
//  2. MULT, q=0xFFFFFFFF00000001, len=1024, dst=src_a=0 (in place) ->
//     1024 consecutive wr_en with no gaps; every word equals the reference model.
//  3. SUB, src_a=1022, src_b=1023, dst=1021, len=3 ->
//     read addresses 1022,1023,0 / 1023,0,1; writes to 1021,1022,1023.
//  4. cmd_op=5, len=8 -> done=1 and err=1 in cycle 1; zero rd_en and zero wr_en.
//     Then len=0 with ADD -> done=1, err=0 in cycle 1.
//  5. rst_n low in cycle 4 of a len=16 command -> outputs go to reset values immediately,
//     no further wr_en. After release, a new command completes correctly.
//  6. VEC_SEQ_PERF_EN: three commands of len 4, 0, 2 -> perf_cmds=3, perf_busy=7+1+5=13.

Source files
------------

// File: rtl/vec_op_sequencer.sv
// Streams one vec_alu op over VRF vectors: read -> ALU -> write, one element per cycle.
// Latency: first write 3 cycles after accept, done in cycle len+3; optional VEC_SEQ_PERF_EN adds perf counters.
// Backpressure: cmd_ready only in IDLE; no stall path once a command runs.
module vec_op_sequencer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [DATA_W-1:0] cmd_q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_q,
    input  logic [DATA_W-1:0] alu_res,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
`ifdef VEC_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cmds,
    output logic [31:0]       perf_busy
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] src_a_r;
    logic [ADDR_W-1:0] src_b_r;
    logic [ADDR_W-1:0] dst_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W-1:0] wr_cnt;
    logic [2:0]        op_r;
    logic [DATA_W-1:0] q_r;
    logic              err_r;
    logic              rd_vld_d;
    logic              accept;
    logic              op_legal;

    assign accept   = cmd_valid && (state == S_IDLE);
    assign op_legal = (cmd_op <= 3'd2);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!op_legal || (cmd_len == '0)) state_nxt = S_DONE;
                    else                              state_nxt = S_RUN;
                end
            end
            S_RUN:   if (rd_cnt == len_r - LEN_ONE) state_nxt = S_DRAIN;
            // rd_vld_d clears in the cycle carrying the final write
            S_DRAIN: if (!rd_vld_d) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            src_a_r  <= '0;
            src_b_r  <= '0;
            dst_r    <= '0;
            len_r    <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            op_r     <= '0;
            q_r      <= '0;
            err_r    <= 1'b0;
            rd_vld_d <= 1'b0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
        end else begin
            state    <= state_nxt;
            rd_vld_d <= rd_en;
            wr_en    <= rd_vld_d;
            if (rd_vld_d) wr_data <= alu_res;
            if (accept) begin
                src_a_r <= cmd_src_a;
                src_b_r <= cmd_src_b;
                dst_r   <= cmd_dst;
                len_r   <= cmd_len;
                op_r    <= cmd_op;
                q_r     <= cmd_q;
                err_r   <= !op_legal;
                rd_cnt  <= '0;
                wr_cnt  <= '0;
            end else begin
                if (state == S_RUN) rd_cnt <= rd_cnt + LEN_ONE;
                if (wr_en)          wr_cnt <= wr_cnt + ADDR_W'(1);
            end
        end
    end

    assign cmd_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign err        = (state == S_DONE) && err_r;
    assign rd_en      = (state == S_RUN);
    assign rd_addr_a  = src_a_r + rd_cnt[ADDR_W-1:0];
    assign rd_addr_b  = src_b_r + rd_cnt[ADDR_W-1:0];
    assign wr_addr    = dst_r + wr_cnt;
    assign alu_opcode = op_r;
    assign alu_q      = q_r;
    assign alu_a      = rd_data_a;
    assign alu_b      = rd_data_b;

`ifdef VEC_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cmds <= '0;
            perf_busy <= '0;
        end else begin
            if (done) perf_cmds <= perf_cmds + 32'd1;
            if (busy) perf_busy <= perf_busy + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Bench for vec_op_sequencer: VRF and vec_alu behavioural models, table-driven
// commands, random commands against a snapshot reference, and reset / perf corner cases.
module tb_vec_op_sequencer;
    localparam int DW = 64;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [AW-1:0] cmd_src_a = '0;
    logic [AW-1:0] cmd_src_b = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [AW:0]   cmd_len = '0;
    logic [DW-1:0] cmd_q = '0;
    logic          busy, done, err, rd_en, wr_en;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
    logic [DW-1:0] rd_data_a = '0;
    logic [DW-1:0] rd_data_b = '0;
    logic [2:0]    alu_opcode;
    logic [DW-1:0] alu_a, alu_b, alu_q, alu_res, wr_data;
`ifdef VEC_SEQ_PERF_EN
    logic [31:0]   perf_cmds, perf_busy;
`endif

    int total = 0;
    int bad = 0;
    logic [DW-1:0] vrf [0:1023];

    always #5 clk = ~clk;

    vec_op_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .cmd_len(cmd_len), .cmd_q(cmd_q), .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .alu_opcode(alu_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_q(alu_q), .alu_res(alu_res),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef VEC_SEQ_PERF_EN
        , .perf_cmds(perf_cmds), .perf_busy(perf_busy)
`endif
    );

    function automatic logic [DW-1:0] modop(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [DW-1:0] q);
        logic [127:0] wa, wb, wq, r;
        wa = {64'd0, a};
        wb = {64'd0, b};
        wq = {64'd0, q};
        r  = '0;
        if (q != '0) begin
            case (op)
                3'd0:    r = (wa + wb) % wq;
                3'd1:    r = (wa + wq - wb) % wq;
                3'd2:    r = (wa * wb) % wq;
                default: r = '0;
            endcase
        end
        return r[DW-1:0];
    endfunction

    // VRF read port with one-cycle latency; the combinational ALU model
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= vrf[rd_addr_a];
            rd_data_b <= vrf[rd_addr_b];
        end
    end
    always_comb alu_res = modop(alu_opcode, alu_a, alu_b, alu_q);

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fill(input logic [DW-1:0] q);
        for (int i = 0; i < 1024; i++) vrf[i] = {$urandom, $urandom} % q;
    endtask

    // One command end to end: expected writes come from a snapshot of the VRF
    task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                           input logic [AW-1:0] dst, input logic [AW:0] len,
                           input logic [DW-1:0] q, input logic exp_err);
        logic [DW-1:0] expw[$];
        logic [AW-1:0] ea, eb;
        int nrd, nwr, done_cyc, n_act, w;
        n_act = (exp_err || len == 0) ? 0 : int'(len);
        for (int i = 0; i < n_act; i++) begin
            ea = sa + AW'(i);
            eb = sb + AW'(i);
            expw.push_back(modop(op, vrf[ea], vrf[eb], q));
        end
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_src_a = sa; cmd_src_b = sb;
        cmd_dst = dst; cmd_len = len; cmd_q = q;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = $urandom; cmd_len = $urandom; cmd_q = '0;
        chk("busy_c1", busy, 1);
        chk("ready_c1", cmd_ready, 0);
        chk("alu_q", alu_q, q);
        chk("alu_opcode", alu_opcode, op);
        nrd = 0; nwr = 0; done_cyc = -1;
        for (int cyc = 1; cyc <= int'(len) + 6; cyc++) begin
            if (rd_en) begin
                ea = sa + AW'(nrd);
                eb = sb + AW'(nrd);
                chk("rd_addr_a", rd_addr_a, ea);
                chk("rd_addr_b", rd_addr_b, eb);
                chk("rd_cycle", cyc, 1 + nrd);
                nrd++;
            end
            if (wr_en) begin
                ea = dst + AW'(nwr);
                chk("wr_addr", wr_addr, ea);
                chk("wr_cycle", cyc, 3 + nwr);
                if (nwr < expw.size()) chk("wr_data", wr_data, expw[nwr]);
                else chk("wr_extra", 1, 0);
                vrf[wr_addr] = wr_data;
                nwr++;
            end
            if (done) begin
                done_cyc = cyc;
                chk("err", err, exp_err);
                break;
            end
            @(negedge clk);
        end
        chk("done_cycle", done_cyc, (n_act == 0) ? 1 : n_act + 3);
        chk("rd_count", nrd, n_act);
        chk("wr_count", nwr, n_act);
        @(negedge clk);
        chk("ready_after", cmd_ready, 1);
        chk("done_after", done, 0);
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] sa, sb, dst;
        logic [AW:0]   len;
        logic [DW-1:0] q;
        logic          exp_err;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        logic [DW-1:0] rq;
        logic [AW-1:0] ra, rb, rd;
        logic [2:0] rop;
        tbl[0] = '{3'd1, 10'd1022, 10'd1023, 10'd1021, 11'd3, 64'd1000003, 1'b0};
        tbl[1] = '{3'd5, 10'd0, 10'd0, 10'd100, 11'd8, 64'd97, 1'b1};
        tbl[2] = '{3'd0, 10'd0, 10'd0, 10'd100, 11'd0, 64'd97, 1'b0};
        tbl[3] = '{3'd2, 10'd100, 10'd200, 10'd300, 11'd5, 64'hFFFFFFFF00000001, 1'b0};
        tbl[4] = '{3'd0, 10'd10, 10'd20, 10'd1020, 11'd8, 64'd12345678901, 1'b0};
        tbl[5] = '{3'd3, 10'd5, 10'd6, 10'd7, 11'd4, 64'd97, 1'b1};
        tbl[6] = '{3'd2, 10'd50, 10'd60, 10'd60, 11'd1, 64'd65537, 1'b0};

        for (int i = 0; i < 1024; i++) vrf[i] = '0;
        #1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_alu_q", alu_q, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // small ADD example with hand-computed results
        vrf[0] = 64'd10; vrf[1] = 64'd90; vrf[16] = 64'd5; vrf[17] = 64'd20;
        run_cmd(3'd0, 10'd0, 10'd16, 10'd32, 11'd2, 64'd97, 1'b0);
        chk("vrf32", vrf[32], 64'd15);
        chk("vrf33", vrf[33], 64'd13);

        for (int t = 0; t < 7; t++) begin
            fill(tbl[t].q);
            run_cmd(tbl[t].op, tbl[t].sa, tbl[t].sb, tbl[t].dst, tbl[t].len, tbl[t].q, tbl[t].exp_err);
        end

        // full-length in-place MULT
        fill(64'hFFFFFFFF00000001);
        run_cmd(3'd2, 10'd0, 10'd0, 10'd0, 11'd1024, 64'hFFFFFFFF00000001, 1'b0);

        for (int r = 0; r < 15; r++) begin
            rq = {$urandom, $urandom} | 64'd3;
            fill(rq);
            rop = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            ra = 10'($urandom_range(0, 255));
            rb = 10'($urandom_range(256, 511));
            case ($urandom_range(0, 2))
                0:       rd = ra;
                1:       rd = rb;
                default: rd = 10'($urandom_range(512, 1023));
            endcase
            run_cmd(rop, ra, rb, rd, 11'($urandom_range(0, 40)), rq, rop > 3'd2);
        end

        // reset in cycle 4 of a len=16 command
        fill(64'd97);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_src_a = 10'd0; cmd_src_b = 10'd100;
        cmd_dst = 10'd200; cmd_len = 11'd16; cmd_q = 64'd97;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_wr_en", wr_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_alu_q", alu_q, 0);
        chk("mid_rst_rd_addr", rd_addr_a, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_hold_wr_en", wr_en, 0);
        end
        rst_n = 1'b1;
        fill(64'd1000003);
        run_cmd(3'd1, 10'd0, 10'd100, 10'd200, 11'd16, 64'd1000003, 1'b0);

`ifdef VEC_SEQ_PERF_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("perf_rst", perf_cmds, 0);
        fill(64'd97);
        run_cmd(3'd0, 10'd0, 10'd10, 10'd20, 11'd4, 64'd97, 1'b0);
        run_cmd(3'd0, 10'd0, 10'd10, 10'd20, 11'd0, 64'd97, 1'b0);
        run_cmd(3'd1, 10'd0, 10'd10, 10'd30, 11'd2, 64'd97, 1'b0);
        chk("perf_cmds", perf_cmds, 32'd3);
        chk("perf_busy", perf_busy, 32'd13);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
